// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the dual-channel ADC serial receiver.
package adc_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LZ_BITS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_DONE  = 2'd2,
    ST_QUIET = 2'd3
  } state_e;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: half-period divider, idle-high sclk, rising-edge strobe and
// frame_end after the last of FRAME_BITS rising edges.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int HALF_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_o,
  output logic frame_end_o
);

  localparam logic [7:0] CNT_LAST  = 8'(HALF_DIV - 1);
  localparam logic [3:0] EDGE_LAST = 4'(FRAME_BITS - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic [3:0] edge_q, edge_d;
  logic       wrap;

  always_comb begin
    wrap        = run_i && (cnt_q == CNT_LAST);
    rise_o      = wrap && !sclk_q;
    frame_end_o = rise_o && (edge_q == EDGE_LAST);
    cnt_d       = cnt_q;
    sclk_d      = sclk_q;
    edge_d      = edge_q;
    if (!run_i) begin
      // Parked between frames: sclk idles high and the next frame starts fresh.
      cnt_d  = '0;
      sclk_d = 1'b1;
      edge_d = '0;
    end else begin
      cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
      if (wrap) sclk_d = ~sclk_q;
      if (rise_o) edge_d = edge_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
      edge_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      edge_q <= edge_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_serial_rx.sv
// Dual ADCS7476 serial front end: frames cs_n/sclk, shifts both channels, latches 12-bit samples.
// Optional ADC_ZERO_CHECK_EN adds frame_err, flagging nonzero leading bits on either channel.
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int HALF_DIV  = 4,
  parameter int QUIET_CYC = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sel,
  input  logic                 sdata1,
  input  logic                 sdata2,
  output logic                 sclk,
  output logic                 cs_n,
  output logic [DATA_BITS-1:0] ch1_data,
  output logic [DATA_BITS-1:0] ch2_data,
  output logic [DATA_BITS-1:0] sample,
  output logic                 valid
`ifdef ADC_ZERO_CHECK_EN
  ,
  output logic                 frame_err
`endif
);

`ifdef ADC_ZERO_CHECK_EN
  localparam int SR_W = FRAME_BITS;
`else
  // Leading zeros simply fall off the top of a DATA_BITS-wide register.
  localparam int SR_W = DATA_BITS;
`endif
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);

  state_e         state_q, state_d;
  logic [7:0]     quiet_q, quiet_d;
  logic           cs_n_q, cs_n_d;
  logic           valid_q;
  logic [DATA_BITS-1:0] ch1_q, ch2_q, sample_q;
  logic           rise_w, frame_end_w;
  logic [1:0]     sdata_w;
  logic [SR_W-1:0] sr_w [2];

  adc_sclk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sclk_gen (
    .clk_i       (clk),
    .rst_ni      (reset),
    .run_i       (state_q == ST_CONV),
    .sclk_o      (sclk),
    .rise_o      (rise_w),
    .frame_end_o (frame_end_w)
  );

  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_CONV;
      ST_CONV:  if (frame_end_w) state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_QUIET;
        quiet_d = '0;
      end
      ST_QUIET: begin
        if (quiet_q == QUIET_LAST) state_d = ST_IDLE;
        else quiet_d = quiet_q + 8'd1;
      end
      default:  state_d = ST_IDLE;
    endcase
    cs_n_d = (state_d != ST_CONV);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      quiet_q <= '0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign sdata_w = {sdata2, sdata1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [SR_W-1:0] sr_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) sr_q <= '0;
        else if (rise_w) sr_q <= {sr_q[SR_W-2:0], sdata_w[gi]};
      end
      assign sr_w[gi] = sr_q;
    end
  endgenerate

  // Data and valid register together so valid is high exactly when the new values are visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      ch1_q    <= '0;
      ch2_q    <= '0;
      sample_q <= '0;
    end else begin
      valid_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        ch1_q    <= sr_w[0][DATA_BITS-1:0];
        ch2_q    <= sr_w[1][DATA_BITS-1:0];
        sample_q <= sel ? sr_w[1][DATA_BITS-1:0] : sr_w[0][DATA_BITS-1:0];
      end
    end
  end

`ifdef ADC_ZERO_CHECK_EN
  logic frame_err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_err_q <= 1'b0;
    else if (state_q == ST_DONE)
      frame_err_q <= (|sr_w[0][FRAME_BITS-1:DATA_BITS]) | (|sr_w[1][FRAME_BITS-1:DATA_BITS]);
  end
  assign frame_err = frame_err_q;
`endif

  assign cs_n     = cs_n_q;
  assign valid    = valid_q;
  assign ch1_data = ch1_q;
  assign ch2_data = ch2_q;
  assign sample   = sample_q;

endmodule
